// File: rtl/inc_dec_pulse_scheduler.sv
// Two-requester round-robin front end for the inc/dec counter: queues ops in a
// small FIFO and replays them as single-cycle inc/dec pulses spaced by GAP idle cycles.
//
// state  | meaning
// IDLE   | nothing in flight, waiting for a queued op
// ISSUE  | one-cycle inc or dec pulse for the op popped on entry
// GAP    | GAP idle cycles after a pulse, timed by gap_cnt down-counter
module inc_dec_pulse_scheduler #(
    parameter int DEPTH = 4,
    parameter int GAP   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   a_valid,
    input  logic                   a_op,
    output logic                   a_ready,
    input  logic                   b_valid,
    input  logic                   b_op,
    output logic                   b_ready,
    output logic                   inc,
    output logic                   dec,
    output logic [$clog2(DEPTH):0] pending,
    output logic                   busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_t;

    state_t         state, state_nxt;
    logic [DEPTH-1:0] mem;
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  gap_cnt;
    logic           full, empty, fav_a;
    logic           grant_a, grant_b, push, push_op, pop, gap_load;

    assign full  = (pending == (AW + 1)'(DEPTH));
    assign empty = (pending == '0);

    // Full is taken from the registered count, so a same-cycle pop never frees a slot for a push.
    always_comb begin
        grant_a = a_valid && !full && (!b_valid || fav_a);
        grant_b = b_valid && !full && (!a_valid || !fav_a);
        push    = grant_a || grant_b;
        push_op = grant_a ? a_op : b_op;
    end

    assign a_ready = grant_a;
    assign b_ready = grant_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fav_a <= 1'b1;
        end else if (grant_a) begin
            fav_a <= 1'b0;
        end else if (grant_b) begin
            fav_a <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem     <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            pending <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_op;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                pending <= pending + 1'b1;
            end else if (!push && pop) begin
                pending <= pending - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        gap_load  = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    state_nxt = S_ISSUE;
                    pop       = 1'b1;
                end
            end
            S_ISSUE: begin
                if (GAP > 0) begin
                    state_nxt = S_GAP;
                    gap_load  = 1'b1;
                end else if (!empty) begin
                    state_nxt = S_ISSUE;
                    pop       = 1'b1;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_cnt == CW'(1)) begin
                    if (!empty) begin
                        state_nxt = S_ISSUE;
                        pop       = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_cnt <= '0;
        end else if (gap_load) begin
            gap_cnt <= CW'(GAP);
        end else if (state == S_GAP) begin
            gap_cnt <= gap_cnt - 1'b1;
        end
    end

    // The pulse register is loaded on the pop edge, so it is high exactly for the ISSUE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inc <= 1'b0;
            dec <= 1'b0;
        end else begin
            inc <= pop && mem[rd_ptr];
            dec <= pop && !mem[rd_ptr];
        end
    end

    assign busy = (state != S_IDLE) || !empty;

endmodule

// File: tb/tb_inc_dec_pulse_scheduler.sv
// Scoreboard bench for inc_dec_pulse_scheduler: a default (GAP=2) instance and a GAP=0 instance.
// Granted ops are queued with their acceptance cycle and matched against observed pulses.
module tb_inc_dec_pulse_scheduler;
    localparam int DEPTH = 4;
    localparam int PW    = $clog2(DEPTH) + 1;

    typedef struct {
        bit op;
        int acc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    a_valid = '0, a_op = '0, b_valid = '0, b_op = '0;
    logic [1:0]    a_ready, b_ready, inc, dec, busy;
    logic [PW-1:0] pending0, pending1;

    exp_t q[$];
    int   n_checks = 0, n_errors = 0;
    int   cyc = 0, cnt = 0, last_p = -1000, ctr = 0, peak = 0;
    bit   fav_a = 1'b1, last_grant = 1'b0, saw_pulse = 1'b0;

    inc_dec_pulse_scheduler #(.DEPTH(DEPTH), .GAP(2)) u_dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid[0]), .a_op(a_op[0]), .a_ready(a_ready[0]),
        .b_valid(b_valid[0]), .b_op(b_op[0]), .b_ready(b_ready[0]),
        .inc(inc[0]), .dec(dec[0]), .pending(pending0), .busy(busy[0])
    );

    inc_dec_pulse_scheduler #(.DEPTH(DEPTH), .GAP(0)) u_dut_g0 (
        .clk(clk), .rst(rst),
        .a_valid(a_valid[1]), .a_op(a_op[1]), .a_ready(a_ready[1]),
        .b_valid(b_valid[1]), .b_op(b_op[1]), .b_ready(b_ready[1]),
        .inc(inc[1]), .dec(dec[1]), .pending(pending1), .busy(busy[1])
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int gap_of(input bit sel);
        return sel ? 0 : 2;
    endfunction

    function automatic int pend_of(input bit sel);
        return sel ? int'(pending1) : int'(pending0);
    endfunction

    task automatic model_reset();
        q.delete();
        cnt    = 0;
        fav_a  = 1'b1;
        last_p = -1000;
    endtask

    task automatic observe(input bit sel, input bit granted);
        bit   p;
        int   exp_c;
        exp_t e;
        p = inc[sel] | dec[sel];
        check("exclusive", 32'(inc[sel] & dec[sel]), 0);
        if (rst) begin
            check("rst_inc", 32'(inc[sel]), 0);
            check("rst_dec", 32'(dec[sel]), 0);
            check("rst_pending", pend_of(sel), 0);
            check("rst_busy", 32'(busy[sel]), 0);
            return;
        end
        if (p) begin
            saw_pulse = 1'b1;
            check("pulse_has_op", 32'(q.size() != 0), 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                check("pulse_op", 32'(inc[sel]), 32'(e.op));
                exp_c = last_p + 1 + gap_of(sel);
                if (e.acc + 1 > exp_c) exp_c = e.acc + 1;
                check("pulse_cycle", cyc, exp_c);
            end
            last_p = cyc;
            ctr = inc[sel] ? (ctr + 1) % 13 : (ctr + 12) % 13;
        end
        cnt = cnt + int'(granted) - int'(p);
        check("pending", pend_of(sel), cnt);
        if (pend_of(sel) > peak) peak = pend_of(sel);
        check("busy", 32'(busy[sel]), 32'((cnt > 0) || (cyc <= last_p + gap_of(sel))));
    endtask

    // Called at a negedge: drive one cycle of inputs, check readies, advance one clock.
    task automatic step(input bit sel, input bit av, input bit aop, input bit bv, input bit bop);
        bit full, ga, gb;
        a_valid[sel] = av;
        a_op[sel]    = aop;
        b_valid[sel] = bv;
        b_op[sel]    = bop;
        #1;
        full = (cnt == DEPTH);
        ga   = av && !full && (!bv || fav_a);
        gb   = bv && !full && !ga;
        check("a_ready", 32'(a_ready[sel]), 32'(ga));
        check("b_ready", 32'(b_ready[sel]), 32'(gb));
        last_grant = 1'b0;
        if (!rst && (ga || gb)) begin
            q.push_back('{op: ga ? aop : bop, acc: cyc + 1});
            fav_a      = gb;
            last_grant = 1'b1;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        observe(sel, last_grant);
    endtask

    task automatic idle(input bit sel, input int n);
        for (int i = 0; i < n; i++) step(sel, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bit pat[6];
        int accepted, start, k;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

        @(negedge clk);
        step(0, 1'b1, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        model_reset();
        idle(0, 2);

        // single inc then single dec
        step(0, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(0, 6);
        check("ctr_after_inc", ctr, 1);
        step(0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(0, 6);
        check("ctr_after_dec", ctr, 0);

        // contention: A inc vs B dec, both held for 4 grants
        for (int i = 0; i < 4; i++) step(0, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(0, 16);
        check("drain_contention", q.size(), 0);

        // back-to-back pushes run into a full FIFO
        start    = ctr;
        peak     = 0;
        accepted = 0;
        for (int i = 0; i < 60 && accepted < 8; i++) begin
            step(0, 1'b1, 1'b1, 1'b0, 1'b0);
            accepted += int'(last_grant);
        end
        check("full_accepted", accepted, 8);
        idle(0, 24);
        check("full_peak", peak, DEPTH);
        check("drain_full", q.size(), 0);
        check("ctr_after_full", ctr, (start + 8) % 13);

        // pattern across pointer wrap; a push lands on a pop edge with pending=2
        k = 0;
        for (int i = 0; i < 40 && k < 6; i++) begin
            if (i == 3) begin
                idle(0, 1);
            end else begin
                step(0, 1'b1, pat[k], 1'b0, 1'b0);
                if (last_grant) k++;
            end
        end
        check("pattern_accepted", k, 6);
        idle(0, 20);
        check("drain_pattern", q.size(), 0);

        // reset asserted while in GAP with an op still queued
        saw_pulse = 1'b0;
        step(0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6 && !saw_pulse; i++) idle(0, 1);
        check("pulse_before_rst", 32'(saw_pulse), 1);
        idle(0, 1);
        rst = 1'b1;
        #1;
        check("rst_async_inc", 32'(inc[0]), 0);
        check("rst_async_dec", 32'(dec[0]), 0);
        check("rst_async_pending", pending0, 0);
        check("rst_async_busy", 32'(busy[0]), 0);
        model_reset();
        idle(0, 2);
        rst = 1'b0;
        idle(0, 8);

        // GAP=0 instance: three queued ops drain as consecutive pulses
        model_reset();
        step(1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(1, 6);
        check("g0_drain", q.size(), 0);
        check("g0_busy_end", 32'(busy[1]), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/inc_dec_pulse_scheduler.md
# inc_dec_pulse_scheduler

Front-end controller for `inc_dec_counter_mod13_mod7`, the increment/decrement counter. Two independent requesters submit increment or decrement operations over valid/ready handshakes. A round-robin arbiter queues the operations in a small FIFO. An issue state machine replays them to the counter as single-cycle `inc` or `dec` pulses separated by a fixed idle gap, so the counter never sees overlapping or simultaneous `inc`/`dec`.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, ≥2.
- `GAP`, default 2: idle cycles after each issued pulse; 0 allowed.

- `clk`  in  1  single clock; all state on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `a_valid`  in  1  requester A has an operation.
- `a_op`  in  1  A's operation: 1 = increment, 0 = decrement.
- `a_ready`  out  1  A's operation accepted this cycle (valid && ready).
- `b_valid`  in  1  requester B has an operation.
- `b_op`  in  1  B's operation: 1 = increment, 0 = decrement.
- `b_ready`  out  1  B's operation accepted this cycle.
- `inc`  out  1  increment pulse to the counter.
- `dec`  out  1  decrement pulse to the counter.
- `pending`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `busy`  out  1  FIFO non-empty or FSM not in IDLE.

## Operation
- **Reset values:** `inc`=0, `dec`=0, `pending`=0, `busy`=0. FIFO is empty, FSM is in IDLE, and the round-robin pointer favours A.
- **Arbitration:**
  - `a_ready`/`b_ready` are combinational from the registered full flag, the valids and the pointer.
  - At most one grant per cycle.
  - If full, both readies are 0. A same-cycle pop does not unblock a push.
  - If only one requester is valid, it is granted.
  - If both are valid, the pointer's favourite is granted.
  - After any grant, the pointer favours the other requester. With no grant, the pointer holds.
  - A ready line with its valid low is don't-care but must not enqueue.
- **FIFO:**
  - 1-bit entries storing the op, in-order.
  - Push on grant, pop on the ISSUE entry.
  - Simultaneous push and pop leaves `pending` unchanged.
  - Wrap-around uses modulo-DEPTH pointers.
- **FSM:** states IDLE, ISSUE, GAP.
  - IDLE → ISSUE when the FIFO is non-empty; the head entry is popped on this edge.
  - ISSUE lasts 1 cycle and drives `inc` = head op, `dec` = !head op. Outputs are registered and decoded from the issue register.
  - ISSUE → GAP if GAP>0.
  - ISSUE → ISSUE if GAP=0 and the FIFO is non-empty; otherwise ISSUE → IDLE.
  - GAP holds for exactly GAP cycles, counted by a down-counter of width $clog2(GAP+1).
  - At the end of GAP: → ISSUE if non-empty, else → IDLE.
- `inc` and `dec` are never high together. Each accepted operation produces exactly one pulse. No operation is dropped or duplicated.
- **Reset mid-operation:** `rst` asserted in any state immediately clears outputs, FIFO, counter and pointer. Queued operations are discarded.

## Timing
- **Acceptance:** the handshake at edge N writes the FIFO. `pending` shows the increment after edge N.
- **Issue latency:** from IDLE with an empty FIFO, `inc`/`dec` go high after edge N+1 and drop after edge N+2. This is one cycle from acceptance to pulse.
- **Pulse period:** 1+GAP cycles under backlog. With the default GAP, that is 3 cycles: one pulse cycle, then two idle posedges.
- **Throughput:** sustained acceptance exceeds drain rate. With backlog, `pending` reaches DEPTH and readies deassert until the next pop edge.
- **`busy`:** combinational from the registered state and `pending`. It falls the cycle after the last GAP cycle completes with an empty FIFO.

## Test plan
- **Reset:** `rst`=1 → `inc`=`dec`=0, `pending`=0, `busy`=0, `a_ready`=1 when `a_valid`=1. Reassert `rst` during GAP → outputs 0 immediately, `pending`=0, and no further pulses.
- **Single op:** `a_valid`=1, `a_op`=1 for one cycle with counter at 0 → `inc` high for exactly one cycle, one cycle after acceptance; counter reads 1. Repeat with `a_op`=0 → single `dec`; counter returns to 0.
- **Contention:** A holds inc and B holds dec, both continuously valid for 4 grants → grant order A,B,A,B. Pulses are `inc`,`dec`,`inc`,`dec`, spaced 3 cycles apart; `inc`&`dec` never both 1.
- **Full FIFO:** A pushes 8 incs back-to-back → `pending` peaks at 4 and `a_ready` drops while full. Exactly 8 `inc` pulses occur; the counter advances by 8 modulo its wrap rule.
- **Same-cycle push/pop:** push lands on the ISSUE-entry edge with `pending`=2 → `pending` stays 2. FIFO order across wrap-around is preserved: the pattern inc,dec,dec,inc,inc,dec is issued identically.
- **GAP=0 build:** 3 queued ops → 3 consecutive single-cycle pulses with no idle cycle between them; then IDLE and `busy`=0.
